// File: rtl/irq_pkg.sv
// Shared definitions for the machine-mode interrupt source block:
// register offsets, timer interrupt code and the line trigger mode.
package irq_pkg;

   localparam int unsigned DEFAULT_N_EXT = 7;

   localparam logic [4:0] MTIME_LO    = 5'h00;
   localparam logic [4:0] MTIME_HI    = 5'h04;
   localparam logic [4:0] MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MODE        = 5'h10;
   localparam logic [4:0] PENDING     = 5'h14;
   localparam logic [4:0] RAW         = 5'h18;

   localparam logic [4:0] TIMER_CODE  = 5'd7;

   typedef enum logic {
      IRQ_LEVEL = 1'b0,
      IRQ_EDGE  = 1'b1
   } irq_mode_e;

endpackage

// File: rtl/irq_line_cond.sv
// Per-line conditioning for one external IRQ: optional synchronizer
// (IRQ_SYNC_EN), rising-edge detect and the pending flop.
// In edge mode a new edge always wins over a simultaneous clear.
module irq_line_cond
   import irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   input  logic mode,
   input  logic clr,
   output logic cond,
   output logic pending
);

   irq_mode_e line_mode;
   logic      prev_q, prev_d;
   logic      pending_q, pending_d;
   logic      edge_set;

   if (SYNC_STAGES < 1) begin : g_bad_sync_stages
      $error("irq_line_cond: SYNC_STAGES must be at least 1");
   end

`ifdef IRQ_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   // Shift the raw line through the synchronizer chain
   always_comb begin
      sync_d    = '0;
      sync_d[0] = irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Synchronizer flops
   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign cond = sync_q[SYNC_STAGES-1];
`else
   assign cond = irq_in;
`endif

   assign line_mode = irq_mode_e'(mode);
   assign edge_set  = cond & ~prev_q;

   // Level lines mirror the input; edge lines latch until cleared
   always_comb begin
      prev_d = cond;
      if (line_mode == IRQ_EDGE) pending_d = edge_set | (pending_q & ~clr);
      else                       pending_d = cond;
   end

   // Edge history and pending state
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: external IRQ capture, prescaled 64-bit
// mtime/mtimecmp timer and a small register window.
// Optional synchronizers on irq_in are enabled by defining IRQ_SYNC_EN.
module irq_source_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned N_EXT       = DEFAULT_N_EXT,
   parameter int unsigned TIMER_DIV   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_EXT-1:0] irq_in,
   input  logic             int_ack,
   input  logic [4:0]       int_ack_code,
   input  logic             bus_wr,
   input  logic             bus_rd,
   input  logic [4:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata,
   output logic [31:0]      mip_in,
   output logic             timer_irq
);

   logic [N_EXT-1:0] mode_q, mode_d;
   logic [N_EXT-1:0] line_clr, line_cond, line_pend;
   logic [63:0]      mtime_q, mtime_d, mtime_inc;
   logic [63:0]      mtimecmp_q, mtimecmp_d;
   logic [15:0]      presc_q, presc_d;
   logic             timer_q, timer_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             tick, ack_ext;
   logic             wr_mode, wr_pending;

   if (N_EXT < 1 || N_EXT > 7) begin : g_bad_n_ext
      $error("irq_source_ctrl: N_EXT must be 1..7");
   end
   if (TIMER_DIV < 1 || TIMER_DIV > 65535) begin : g_bad_timer_div
      $error("irq_source_ctrl: TIMER_DIV must be 1..65535");
   end

   assign wr_mode    = bus_wr && (bus_addr == MODE);
   assign wr_pending = bus_wr && (bus_addr == PENDING);
   assign ack_ext    = int_ack && (int_ack_code != TIMER_CODE);

   // Per-line clear requests; lines in level mode ignore them.
   // An edge-to-level MODE write clears the latched edge via the same path.
   always_comb begin
      line_clr = '0;
      for (int unsigned i = 0; i < N_EXT; i++) begin
         line_clr[i] = (ack_ext && (int_ack_code == 5'(i)))
                     || (wr_pending && bus_wdata[i])
                     || (wr_mode && !bus_wdata[i]);
      end
   end

   for (genvar g = 0; g < N_EXT; g++) begin : g_line
      irq_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line (
         .clk     (clk),
         .reset   (reset),
         .irq_in  (irq_in[g]),
         .mode    (mode_q[g]),
         .clr     (line_clr[g]),
         .cond    (line_cond[g]),
         .pending (line_pend[g])
      );
   end

   // Prescaler, mtime update with per-half bus loads, compare and register writes.
   // A half-write replaces only that half of the incremented value, so an
   // increment on the other half still applies and a LO->HI carry is lost.
   always_comb begin
      tick      = (presc_q == 16'(TIMER_DIV - 1));
      presc_d   = tick ? '0 : presc_q + 16'd1;
      mtime_inc = mtime_q + 64'(tick);
      mtime_d   = mtime_inc;
      if (bus_wr && bus_addr == MTIME_LO) mtime_d[31:0]  = bus_wdata;
      if (bus_wr && bus_addr == MTIME_HI) mtime_d[63:32] = bus_wdata;
      mtimecmp_d = mtimecmp_q;
      if (bus_wr && bus_addr == MTIMECMP_LO) mtimecmp_d[31:0]  = bus_wdata;
      if (bus_wr && bus_addr == MTIMECMP_HI) mtimecmp_d[63:32] = bus_wdata;
      timer_d = (mtime_q >= mtimecmp_q);
      mode_d  = wr_mode ? bus_wdata[N_EXT-1:0] : mode_q;
   end

   // Pending vector presented to the core
   always_comb begin
      mip_in             = '0;
      mip_in[N_EXT-1:0]  = line_pend;
      mip_in[7]          = timer_q;
   end

   // Register read mux; the result is held until the next read
   always_comb begin
      rdata_d = rdata_q;
      if (bus_rd) begin
         case (bus_addr)
            MTIME_LO:    rdata_d = mtime_q[31:0];
            MTIME_HI:    rdata_d = mtime_q[63:32];
            MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
            MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
            MODE:        rdata_d = 32'(mode_q);
            PENDING:     rdata_d = 32'(mip_in[7:0]);
            RAW:         rdata_d = 32'(line_cond);
            default:     rdata_d = '0;
         endcase
      end
   end

   // Timer, mode and read-data state
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         presc_q    <= '0;
         timer_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         mode_q     <= mode_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         presc_q    <= presc_d;
         timer_q    <= timer_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus_rdata = rdata_q;
   assign timer_irq = timer_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Self-checking bench for irq_source_ctrl: directed steps followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_irq_source_ctrl;

   localparam int unsigned DIV = 4;
`ifdef IRQ_SYNC_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  irq_in = '0;
   logic        int_ack = 1'b0;
   logic [4:0]  int_ack_code = '0;
   logic        bus_wr = 1'b0;
   logic        bus_rd = 1'b0;
   logic [4:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic [31:0] mip_in;
   logic        timer_irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit [6:0]  m_pend, m_prev, m_mode;
   bit        m_timer;
   bit [63:0] m_mtime, m_cmp;
   int unsigned m_presc;
   bit [31:0] m_rdata;
   bit [6:0]  m_hist[$];

   irq_source_ctrl #(.N_EXT(7), .TIMER_DIV(DIV), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .int_ack(int_ack),
      .int_ack_code(int_ack_code), .bus_wr(bus_wr), .bus_rd(bus_rd),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .mip_in(mip_in), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] m_read(input bit [4:0] a, input bit [6:0] c);
      case (a)
         5'h00:   return m_mtime[31:0];
         5'h04:   return m_mtime[63:32];
         5'h08:   return m_cmp[31:0];
         5'h0C:   return m_cmp[63:32];
         5'h10:   return {25'b0, m_mode};
         5'h14:   return {24'b0, m_timer, m_pend};
         5'h18:   return {25'b0, c};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_edge();
      bit [6:0]  c, set, clr;
      bit        inc;
      bit [63:0] nxt;
      if (reset) begin
         m_pend = '0; m_prev = '0; m_mode = '0; m_timer = 1'b0;
         m_mtime = '0; m_cmp = '1; m_presc = 0; m_rdata = '0;
         m_hist = {};
         repeat (LAT) m_hist.push_back(7'h0);
         return;
      end
      m_hist.push_back(irq_in);
      c = m_hist.pop_front();
      if (bus_rd) m_rdata = m_read(bus_addr, c);
      set = c & ~m_prev;
      clr = '0;
      if (int_ack && int_ack_code < 5'd7) clr |= 7'(1 << int_ack_code);
      if (bus_wr && bus_addr == 5'h14) clr |= bus_wdata[6:0];
      if (bus_wr && bus_addr == 5'h10) clr |= ~bus_wdata[6:0];
      m_pend  = (m_mode & (set | (m_pend & ~clr))) | (~m_mode & c);
      m_timer = (m_mtime >= m_cmp);
      inc     = (m_presc == DIV - 1);
      m_presc = inc ? 0 : m_presc + 1;
      nxt     = m_mtime + 64'(inc);
      if (bus_wr && bus_addr == 5'h00) nxt[31:0]  = bus_wdata;
      if (bus_wr && bus_addr == 5'h04) nxt[63:32] = bus_wdata;
      m_mtime = nxt;
      if (bus_wr && bus_addr == 5'h08) m_cmp[31:0]  = bus_wdata;
      if (bus_wr && bus_addr == 5'h0C) m_cmp[63:32] = bus_wdata;
      if (bus_wr && bus_addr == 5'h10) m_mode = bus_wdata[6:0];
      m_prev = c;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      expect32("mip_in", mip_in, {24'b0, m_timer, m_pend});
      expect32("timer_irq", {31'b0, timer_irq}, {31'b0, m_timer});
      expect32("bus_rdata", bus_rdata, m_rdata);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
      tick();
      bus_wr = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a);
      bus_rd = 1'b1; bus_addr = a;
      tick();
      bus_rd = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] exp;
      bit [4:0] ra;

      // Reset, then every register
      reset = 1'b1;
      tick(); tick();
      expect32("reset_mip", mip_in, 32'h0);
      expect32("reset_rdata", bus_rdata, 32'h0);
      reset = 1'b0;
      for (int unsigned a = 0; a < 32; a += 4) begin
         rd(5'(a));
         exp = (a == 8 || a == 12) ? 32'hFFFF_FFFF : 32'h0;
         expect32($sformatf("reset_read_%0h", a), bus_rdata, exp);
      end

      // Edge line 0: latch, ack, and edge coinciding with ack
      wr(5'h10, 32'h01);
      irq_in[0] = 1'b1; tick();
      expect32("edge0_set", {31'b0, mip_in[0]}, 32'h1);
      irq_in[0] = 1'b0; tick();
      expect32("edge0_hold", {31'b0, mip_in[0]}, 32'h1);
      int_ack = 1'b1; int_ack_code = 5'd0; tick();
      int_ack = 1'b0;
      expect32("edge0_ack", {31'b0, mip_in[0]}, 32'h0);
      irq_in[0] = 1'b1; int_ack = 1'b1; tick();
      expect32("edge0_set_wins", {31'b0, mip_in[0]}, 32'h1);
      irq_in[0] = 1'b0; int_ack = 1'b0; tick();

      // Level line 2 for 5 cycles, ack mid-way ignored
      n = 0;
      for (int i = 0; i < 9; i++) begin
         irq_in[2] = (i < 5);
         int_ack = (i == 2); int_ack_code = 5'd2;
         tick();
         if (mip_in[2]) n++;
      end
      int_ack = 1'b0;
      expect32("level2_width", 32'(n), 32'd5);

      // Prescaled timer compare
      wr(5'h0C, 32'h0); wr(5'h08, 32'd10);
      wr(5'h04, 32'h0); wr(5'h00, 32'h0);
      n = 0;
      while (!timer_irq && n < 100) begin tick(); n++; end
      expect32("timer_rise", {31'b0, timer_irq}, 32'h1);
      wr(5'h08, 32'd100);
      tick();
      expect32("timer_fall", {31'b0, timer_irq}, 32'h0);

      // mtime wrap
      wr(5'h04, 32'hFFFF_FFFF); wr(5'h00, 32'hFFFF_FFFF);
      repeat (8) tick();
      rd(5'h04);
      expect32("mtime_wrap_hi", bus_rdata, 32'h0);
      expect32("timer_after_wrap", {31'b0, timer_irq}, 32'h0);

      // W1C on edge lines 1 and 3
      wr(5'h10, 32'h0A);
      irq_in = 7'h0A; tick();
      expect32("edge13_set", mip_in & 32'h0A, 32'h0A);
      irq_in = 7'h00; wr(5'h14, 32'h0A);
      expect32("w1c13", mip_in & 32'h0A, 32'h0);
      irq_in = 7'h0A; tick();
      irq_in = 7'h00; tick();
      irq_in = 7'h08; wr(5'h14, 32'h0A);
      expect32("w1c_vs_edge", mip_in & 32'h0A, 32'h08);
      irq_in = 7'h00; tick();

      // Latency on level line 5
      irq_in[5] = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!mip_in[5] && n < 10);
      expect32("irq_latency", 32'(n), 32'(LAT + 1));
      irq_in[5] = 1'b0; tick(); tick();

      // Edge-to-level switch drops the latched edge
      wr(5'h10, 32'h10);
      irq_in[4] = 1'b1; tick();
      irq_in[4] = 1'b0; tick();
      wr(5'h10, 32'h00);
      expect32("mode_switch_clear", {31'b0, mip_in[4]}, 32'h0);

      // Randomized traffic
      wr(5'h0C, 32'h0); wr(5'h04, 32'h0);
      for (int i = 0; i < 800; i++) begin
         irq_in       = 7'($urandom);
         int_ack      = ($urandom_range(0, 3) == 0);
         int_ack_code = 5'($urandom_range(0, 9));
         bus_wr = 1'b0; bus_rd = 1'b0;
         bus_wdata = $urandom;
         ra = 5'($urandom_range(0, 7) * 4);
         case ($urandom_range(0, 15))
            0, 1: begin bus_wr = 1'b1; bus_addr = 5'h10; end
            2:    begin bus_wr = 1'b1; bus_addr = 5'h14; end
            3:    begin bus_wr = 1'b1; bus_addr = 5'h08; bus_wdata = $urandom_range(0, 300); end
            4:    begin bus_wr = 1'b1; bus_addr = 5'h00; bus_wdata = $urandom_range(0, 300); end
            5:    begin bus_wr = 1'b1; bus_addr = ra; bus_rd = 1'b1; end
            6, 7, 8, 9: begin bus_rd = 1'b1; bus_addr = ra; end
            default: bus_addr = ra;
         endcase
         if (bus_wr && (bus_addr == 5'h04 || bus_addr == 5'h0C)) bus_wdata = '0;
         reset = ($urandom_range(0, 150) == 0);
         tick();
      end
      reset = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; int_ack = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
